req_ack_responder: RTL and testbench
====================================

// Module: req_ack_responder
// PURPOSE
//  Single-clock receive side of a 4-phase req/ack bundled-data handshake. It synchronises an
//  asynchronous req and captures data. It then issues a one-cycle data_valid and raises ack until
//  req is withdrawn. Its outputs are the signals the SVA handshake properties check: data_valid ##1 ack.
// PARAMETERS
//  DATA_W       8   width of data_in/data_out
//  SYNC_STAGES  2   flops in req synchroniser (>=2)
//  ACK_DELAY    1   cycles from data_valid rise to ack rise (>=1)
//  TIMEOUT      15  max cycles ack may stay high with req_s still high before timeout_err (>=1)
// PORTS
//  clk          in   1       sole clock; all logic on posedge clk
//  rst          in   1       synchronous, active-high reset
//  req_async    in   1       handshake request from foreign domain
//  data_in      in   DATA_W  bundled data; sender holds stable while req high
//  data_valid   out  1       one-cycle strobe: data_out newly captured
//  data_out     out  DATA_W  captured data; holds until next capture
//  ack          out  1       handshake acknowledge (4-phase level)
//  busy         out  1       high whenever state != IDLE
//  proto_err    out  1       one-cycle pulse: req withdrawn before ack
//  timeout_err  out  1       sticky; cleared only by rst
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, sync chain=0, counters=0, all outputs 0 incl. data_out.
//    Reset mid-handshake aborts silently: no proto_err, and ack drops the next cycle.
//  - req_s = req_async after SYNC_STAGES flops; the FSM uses only req_s.
//  - FSM states: IDLE, VALID, DELAY, ACK.
//    IDLE : req_s=1 -> VALID; data_out<=data_in in the same edge; data_valid=1 next cycle.
//    VALID: one cycle only; data_valid=1. req_s=0 -> IDLE with proto_err pulse.
//           Otherwise ACK_DELAY==1 -> ACK, else -> DELAY with dcnt=ACK_DELAY-2.
//    DELAY: req_s=0 -> IDLE with proto_err. dcnt==0 -> ACK; else dcnt--.
//    ACK  : ack=1 (registered; first high the cycle after VALID/DELAY exit). tcnt counts ACK cycles.
//           req_s=0 -> IDLE, ack=0 next cycle, tcnt=0.
//           tcnt reaching TIMEOUT with req_s=1 -> timeout_err<=1; stay in ACK, tcnt saturates.
//  - Latency, req_async rise to data_valid: SYNC_STAGES+1 cycles.
//    data_valid rise to ack rise: exactly ACK_DELAY cycles.
//  - data_valid and ack are never high in the same cycle. ack never rises without a preceding data_valid.
//  - req_s rising again in the IDLE cycle right after ACK exit starts a new transfer normally.
//    Back-to-back transfers are allowed.
//  - Precedence: proto_err beats progress when req_s falls in the same cycle dcnt expires.
//  - Counters: dcnt width $clog2(ACK_DELAY+1); tcnt width $clog2(TIMEOUT+1); saturating, no wrap.
// CONFIGURATION
//  REQ_ACK_RESPONDER_ASSERT_EN defined: embeds single-clock concurrent assertions @(posedge clk)
//   disable iff (rst):
//   - data_valid |-> ##ACK_DELAY ack, unless proto_err;
//   - $rose(ack) |-> $past(data_valid,ACK_DELAY);
//   - !(data_valid && ack);
//   - $onehot0 of state;
//   - $stable(data_out) unless data_valid.
//  Undefined: no assertion code is compiled; RTL behaviour is identical.
// STRUCTURE
//  Package req_ack_pkg:
//   - typedef enum logic [1:0] {IDLE,VALID,DELAY,ACK} hs_state_e;
//   - localparam MIN_SYNC_STAGES=2.
//  Sub-module bit_synchronizer (param STAGES, ports clk,rst,d,q) implements the req synchroniser.
//  Parameter legality is checked by elaboration-time $error when SYNC_STAGES<2, ACK_DELAY<1 or TIMEOUT<1.
// TESTING (defaults unless noted; cycles counted from the posedge where req_async is first sampled 1)
//  1 Basic: data_in=8'hA5, req_async 0->1 -> data_valid=1 at cycle 3, data_out=8'hA5;
//    ack=1 at cycle 4; busy=1 from cycle 3.
//  2 Release: drop req_async at cycle 10 -> ack=0 at cycle 13; busy=0; second transfer with 8'h3C
//    -> data_out=8'h3C and proto_err stays 0.
//  3 Abort, ACK_DELAY=4: drop req at cycle 3 -> proto_err pulses for one cycle, ack never rises,
//    data_out keeps the captured value.
//  4 Timeout, TIMEOUT=15: hold req high -> timeout_err=1 after 15 ack cycles; stays 1 after req drops;
//    clears only on rst.
//  5 Reset mid-op: assert rst for one cycle while ack=1 -> next cycle all outputs 0, data_out=0,
//    state IDLE; no proto_err.
//  6 Sync depth, SYNC_STAGES=3, ACK_DELAY=2: data_valid at cycle 4, ack at cycle 6;
//    assertions (macro defined) never fire.

Source files
------------

// File: rtl/req_ack_responder_pkg.sv
// Shared types and constants for the req/ack receive-side responder.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DELAY = 2'd2,
    ACK   = 2'd3
  } hs_state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/req_ack_responder_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level; q lags d by STAGES clocks.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // shift chain, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/req_ack_responder.sv
// Receive side of a 4-phase req/ack bundled-data handshake with registered outputs.
// Optional embedded handshake assertions: define REQ_ACK_RESPONDER_ASSERT_EN.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic              busy,
  output logic              proto_err,
  output logic              timeout_err
);

  localparam int DCNT_W = $clog2(ACK_DELAY + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DCNT_W-1:0] DCNT_INIT = (ACK_DELAY >= 2) ? DCNT_W'(ACK_DELAY - 2) : '0;
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("req_ack_responder: SYNC_STAGES must be >= 2");
  end
  if (ACK_DELAY < 1) begin : g_bad_delay
    $error("req_ack_responder: ACK_DELAY must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("req_ack_responder: TIMEOUT must be >= 1");
  end

  logic              w_req_s;
  hs_state_e         r_state, w_state_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic              w_capture, w_abort;
  logic              w_dv_nxt, w_ack_nxt, w_busy_nxt, w_to_nxt;
  logic              r_data_valid, r_ack, r_busy, r_proto_err, r_timeout_err;
  logic [DATA_W-1:0] r_data_out;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_async),
    .q   (w_req_s)
  );

  // state, counters and captured data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dcnt     <= '0;
      r_tcnt     <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_capture) begin
        r_data_out <= data_in;
      end
    end
  end

  // next-state: a withdrawn req is checked before any progress, so abort wins on a tie
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_tcnt_nxt  = r_tcnt;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s) begin
          w_state_nxt = VALID;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      VALID: begin
        if (!w_req_s) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (ACK_DELAY == 1) begin
          w_state_nxt = ACK;
          w_tcnt_nxt  = '0;
        end else begin
          w_state_nxt = DELAY;
          w_dcnt_nxt  = DCNT_INIT;
        end
      end
      DELAY: begin
        if (!w_req_s) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (r_dcnt == '0) begin
          w_state_nxt = ACK;
          w_tcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end
      end
      ACK: begin
        if (!w_req_s) begin
          w_state_nxt = IDLE;
          w_tcnt_nxt  = '0;
        end else if (r_tcnt != TCNT_MAX) begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // outputs decoded from the next state so they line up with the state register
  always_comb begin
    w_dv_nxt   = (w_state_nxt == VALID);
    w_ack_nxt  = (w_state_nxt == ACK);
    w_busy_nxt = (w_state_nxt != IDLE);
    w_to_nxt   = r_timeout_err |
                 ((r_state == ACK) && w_req_s && (w_tcnt_nxt == TCNT_MAX));
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_valid  <= 1'b0;
      r_ack         <= 1'b0;
      r_busy        <= 1'b0;
      r_proto_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_data_valid  <= w_dv_nxt;
      r_ack         <= w_ack_nxt;
      r_busy        <= w_busy_nxt;
      r_proto_err   <= w_abort;
      r_timeout_err <= w_to_nxt;
    end
  end

  assign data_valid  = r_data_valid;
  assign data_out    = r_data_out;
  assign ack         = r_ack;
  assign busy        = r_busy;
  assign proto_err   = r_proto_err;
  assign timeout_err = r_timeout_err;

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
  a_dv_then_ack: assert property (@(posedge clk) disable iff (rst)
    data_valid |-> ((##[1:ACK_DELAY] proto_err) or (##ACK_DELAY ack)));
  a_ack_after_dv: assert property (@(posedge clk) disable iff (rst)
    $rose(ack) |-> $past(data_valid, ACK_DELAY));
  a_dv_ack_excl: assert property (@(posedge clk) disable iff (rst)
    !(data_valid && ack));
  a_state_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({r_state == IDLE, r_state == VALID, r_state == DELAY, r_state == ACK}));
  a_dout_stable: assert property (@(posedge clk) disable iff (rst)
    (!data_valid && !$past(rst)) |-> $stable(data_out));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench: default instance, ACK_DELAY=4 instance, SYNC_STAGES=3/ACK_DELAY=2 instance.
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, req2;
  logic [7:0] din;

  logic       dv0, ack0, busy0, pe0, to0;
  logic       dv1, ack1, busy1, pe1, to1;
  logic       dv2, ack2, busy2, pe2, to2;
  logic [7:0] dout0, dout1, dout2;

  int n_chk = 0;
  int n_bad = 0;
  int rel   = 0;
  int pe_cnt0 = 0, pe_cnt1 = 0, pe_cnt2 = 0;
  int ack_cnt1 = 0;
  int ack_snap;

  always #5 clk = ~clk;

  req_ack_responder u_dut0 (
    .clk(clk), .rst(rst), .req_async(req0), .data_in(din),
    .data_valid(dv0), .data_out(dout0), .ack(ack0), .busy(busy0),
    .proto_err(pe0), .timeout_err(to0)
  );

  req_ack_responder #(.ACK_DELAY(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_async(req1), .data_in(din),
    .data_valid(dv1), .data_out(dout1), .ack(ack1), .busy(busy1),
    .proto_err(pe1), .timeout_err(to1)
  );

  req_ack_responder #(.SYNC_STAGES(3), .ACK_DELAY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_async(req2), .data_in(din),
    .data_valid(dv2), .data_out(dout2), .ack(ack2), .busy(busy2),
    .proto_err(pe2), .timeout_err(to2)
  );

  // pulse/level counters sampled mid-cycle
  always @(negedge clk) begin
    if (pe0)  pe_cnt0++;
    if (pe1)  pe_cnt1++;
    if (pe2)  pe_cnt2++;
    if (ack1) ack_cnt1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rel++;
  endtask

  task automatic goto(input int n);
    while (rel < n) tick();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_dv",   dv0,   32'd0);
    check_eq("rst_ack",  ack0,  32'd0);
    check_eq("rst_busy", busy0, 32'd0);
    check_eq("rst_pe",   pe0,   32'd0);
    check_eq("rst_to",   to0,   32'd0);
    check_eq("rst_dout", dout0, 32'h00);

    // basic transfer, default parameters
    rel = 0; din = 8'hA5; req0 = 1'b1;
    goto(2);  check_eq("t1_dv_early", dv0, 32'd0); check_eq("t1_busy_early", busy0, 32'd0);
    goto(3);  check_eq("t1_dv", dv0, 32'd1); check_eq("t1_dout", dout0, 32'hA5);
              check_eq("t1_busy", busy0, 32'd1); check_eq("t1_ack_early", ack0, 32'd0);
    goto(4);  check_eq("t1_ack", ack0, 32'd1); check_eq("t1_dv_once", dv0, 32'd0);
    goto(10); req0 = 1'b0;
    goto(12); check_eq("t2_ack_hold", ack0, 32'd1);
    goto(13); check_eq("t2_ack_rel", ack0, 32'd0); check_eq("t2_busy_rel", busy0, 32'd0);

    // second transfer
    goto(14);
    rel = 0; din = 8'h3C; req0 = 1'b1;
    goto(3);  check_eq("t2b_dv", dv0, 32'd1); check_eq("t2b_dout", dout0, 32'h3C);
    goto(4);  check_eq("t2b_ack", ack0, 32'd1); req0 = 1'b0;
    goto(7);  check_eq("t2b_ack_rel", ack0, 32'd0);
    goto(9);  check_eq("t2b_dout_hold", dout0, 32'h3C); check_eq("t2_no_pe", pe_cnt0, 32'd0);

    // ACK_DELAY=4: normal latency, then early withdrawal
    rel = 0; din = 8'hC3; req1 = 1'b1;
    goto(3);  check_eq("t3_dv", dv1, 32'd1); check_eq("t3_dout", dout1, 32'hC3);
    goto(6);  check_eq("t3_ack_early", ack1, 32'd0);
    goto(7);  check_eq("t3_ack", ack1, 32'd1); req1 = 1'b0;
    goto(10); check_eq("t3_ack_rel", ack1, 32'd0);
    goto(12);
    ack_snap = ack_cnt1;
    rel = 0; din = 8'h5A; req1 = 1'b1;
    goto(3);  check_eq("t3a_dv", dv1, 32'd1); check_eq("t3a_dout", dout1, 32'h5A); req1 = 1'b0;
    goto(5);  check_eq("t3a_pe_early", pe1, 32'd0); check_eq("t3a_busy", busy1, 32'd1);
    goto(6);  check_eq("t3a_pe", pe1, 32'd1); check_eq("t3a_busy_off", busy1, 32'd0);
    goto(7);  check_eq("t3a_pe_pulse", pe1, 32'd0);
    goto(12); check_eq("t3a_dout_keep", dout1, 32'h5A); check_eq("t3a_pe_cnt", pe_cnt1, 32'd1);
              check_eq("t3a_no_ack", ack_cnt1, ack_snap);

    // SYNC_STAGES=3, ACK_DELAY=2
    rel = 0; din = 8'h96; req2 = 1'b1;
    goto(3);  check_eq("t6_dv_early", dv2, 32'd0);
    goto(4);  check_eq("t6_dv", dv2, 32'd1); check_eq("t6_dout", dout2, 32'h96);
    goto(5);  check_eq("t6_ack_early", ack2, 32'd0);
    goto(6);  check_eq("t6_ack", ack2, 32'd1); req2 = 1'b0;
    goto(10); check_eq("t6_ack_rel", ack2, 32'd0);
    goto(12);
    // req_s falls in the same cycle the delay count expires
    rel = 0; din = 8'h69; req2 = 1'b1;
    goto(2);  req2 = 1'b0;
    goto(4);  check_eq("t6p_dv", dv2, 32'd1); check_eq("t6p_dout", dout2, 32'h69);
    goto(5);  check_eq("t6p_busy", busy2, 32'd1);
    goto(6);  check_eq("t6p_pe", pe2, 32'd1); check_eq("t6p_ack", ack2, 32'd0);
    goto(10); check_eq("t6p_pe_cnt", pe_cnt2, 32'd1);

    // timeout, default TIMEOUT=15
    rel = 0; din = 8'h11; req0 = 1'b1;
    goto(4);  check_eq("t4_ack", ack0, 32'd1);
    goto(18); check_eq("t4_to_early", to0, 32'd0);
    goto(19); check_eq("t4_to", to0, 32'd1);
    goto(22); check_eq("t4_ack_stay", ack0, 32'd1); req0 = 1'b0;
    goto(25); check_eq("t4_ack_rel", ack0, 32'd0);
    goto(27); check_eq("t4_to_sticky", to0, 32'd1); check_eq("t4_busy", busy0, 32'd0);

    // reset in the middle of an acknowledged handshake
    rel = 0; din = 8'h22; req0 = 1'b1;
    goto(6);  check_eq("t5_ack_pre", ack0, 32'd1); rst = 1'b1;
    goto(7);  rst = 1'b0; req0 = 1'b0;
    check_eq("t5_dv", dv0, 32'd0);   check_eq("t5_ack", ack0, 32'd0);
    check_eq("t5_busy", busy0, 32'd0); check_eq("t5_pe", pe0, 32'd0);
    check_eq("t5_to", to0, 32'd0);   check_eq("t5_dout", dout0, 32'h00);
    goto(14); check_eq("t5_idle_dv", dv0, 32'd0); check_eq("t5_no_pe", pe_cnt0, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
